gf2_poly_div_seq: RTL and testbench



---
 rtl/gf2_poly_div_seq_pkg.sv | 11 +
 rtl/gf2_poly_div_seq_if.sv | 16 +
 rtl/gf2_poly_div_seq_deg_encoder.sv | 16 +
 rtl/gf2_poly_div_seq.sv | 90 +++++++++
 tb/tb_gf2_poly_div_seq.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/gf2_poly_div_seq_pkg.sv
// gf2_div_pkg: shared sizes and FSM state codes for the GF(2) long divider
package gf2_div_pkg;
  localparam int N = 103;
  localparam int DW = 2 * N - 1;
  localparam int CW = $clog2(DW);
  localparam int DGW = $clog2(N);
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t DIV = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/gf2_poly_div_seq_if.sv
// gf2_poly_div_seq_if: operand and result valid/ready bundle for the divider
interface gf2_poly_div_seq_if;
  import gf2_div_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [DW-1:0] dividend, quotient;
  logic [N-1:0] divisor;
  logic [N-2:0] remainder;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/gf2_poly_div_seq_deg_encoder.sv
// gf2_deg_encoder: index of the highest set bit plus an all-zero flag
module gf2_deg_encoder #(
  parameter int N = 103,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] v,
  output logic [W-1:0] idx,
  output logic         zero
);
  // scan upward so the last hit is the highest set bit
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) if (v[i]) idx = W'(i);
    zero = ~|v;
  end
endmodule

// File: rtl/gf2_poly_div_seq.sv
// gf2_poly_div_seq: sequential GF(2) long divider, one dividend bit per edge (two with GF2_DIV_DOUBLE_STEP_EN)
module gf2_poly_div_seq
  import gf2_div_pkg::*;
(
  input logic clk,
  input logic rst,
  gf2_poly_div_seq_if.slave bus
);
  state_t state;
  logic [DW-1:0] dvd, q, qn, quo;
  logic [N-2:0] dvs, r, r1, rn, rem;
  logic [N-1:0] t1;
  logic [DGW-1:0] deg, enc_deg;
  logic [CW-1:0] cnt, cnt_lo;
  logic enc_zero, q1, q2, two, last, dbz;
`ifdef GF2_DIV_DOUBLE_STEP_EN
  logic [N-1:0] t2;
`endif
  gf2_deg_encoder #(.N(N), .W(DGW)) u_enc (.v(bus.divisor), .idx(enc_deg), .zero(enc_zero));
  // one long-division step, optionally chained with a second on the next lower bit
  always_comb begin
    cnt_lo = cnt - CW'(1);
    t1 = {r, dvd[cnt]};
    q1 = t1[deg];
    r1 = q1 ? t1[N-2:0] ^ dvs : t1[N-2:0];
`ifdef GF2_DIV_DOUBLE_STEP_EN
    two = !(DW % 2 == 1 && cnt == CW'(DW - 1));
    t2 = {r1, dvd[cnt_lo]};
    q2 = t2[deg];
    rn = two ? (q2 ? t2[N-2:0] ^ dvs : t2[N-2:0]) : r1;
`else
    two = 1'b0;
    q2 = 1'b0;
    rn = r1;
`endif
    qn = q;
    qn[cnt] = q1;
    if (two) qn[cnt_lo] = q2;
    last = cnt == (two ? CW'(1) : CW'(0));
  end
  // handshake FSM with latched operands and held results
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      dvd <= '0;
      dvs <= '0;
      deg <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else case (state)
      IDLE: if (bus.in_valid) begin
        dvd <= bus.dividend;
        dvs <= bus.divisor[N-2:0];
        deg <= enc_deg;
        r <= '0;
        q <= '0;
        cnt <= CW'(DW - 1);
        dbz <= enc_zero;
        if (enc_zero) begin
          quo <= '0;
          rem <= '0;
        end
        state <= enc_zero ? DONE : DIV;
      end
      DIV: begin
        r <= rn;
        q <= qn;
        cnt <= cnt - (two ? CW'(2) : CW'(1));
        if (last) begin
          quo <= qn;
          rem <= rn;
          state <= DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        dbz <= 1'b0;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = quo;
  assign bus.remainder = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// tb_gf2_poly_div_seq: randomized divider checks against a textbook long-division model
module tb_gf2_poly_div_seq;
  import gf2_div_pkg::*;
`ifdef GF2_DIV_DOUBLE_STEP_EN
  localparam int LAT = (DW + 1) / 2;
`else
  localparam int LAT = DW;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  gf2_poly_div_seq_if bus();
  gf2_poly_div_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [DW-1:0] p = '0;
    for (int i = 0; i < N; i++) if (b[i]) p ^= DW'(a) << i;
    return p;
  endfunction
  task automatic ref_div(input logic [DW-1:0] a, input logic [N-1:0] b,
                         output logic [DW-1:0] qq, output logic [N-2:0] rr, output logic z);
    logic [DW-1:0] rm;
    int d;
    z = b == '0;
    qq = '0;
    rr = '0;
    if (z) return;
    d = 0;
    for (int i = 0; i < N; i++) if (b[i]) d = i;
    rm = a;
    for (int i = DW - 1; i >= d; i--)
      if (rm[i]) begin
        rm ^= DW'(b) << (i - d);
        qq[i-d] = 1'b1;
      end
    rr = rm[N-2:0];
  endtask
  function automatic logic [DW-1:0] rnd_dw();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < 7; i++) v = (v << 32) | DW'($urandom());
    return v;
  endfunction
  function automatic logic [N-1:0] rnd_n();
    logic [N-1:0] v = '0;
    for (int i = 0; i < 4; i++) v = (v << 32) | N'($urandom());
    return v;
  endfunction
  task automatic do_op(input logic [DW-1:0] a, input logic [N-1:0] b, input int stall,
                       output logic [DW-1:0] gq, output logic [N-2:0] gr);
    logic [DW-1:0] eq;
    logic [N-2:0] er;
    logic ez;
    int n;
    ref_div(a, b, eq, er, ez);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept", DW'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 2 * DW) begin
      @(negedge clk);
      n++;
      if (n == 3) begin
        bus.in_valid = 1'b1;
        bus.dividend = ~a;
        bus.divisor = ~b;
      end
      if (n == 4) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("latency", DW'(n), ez ? 0 : LAT);
    chk("quotient", bus.quotient, eq);
    chk("remainder", DW'(bus.remainder), DW'(er));
    chk("div_by_zero", DW'(bus.div_by_zero), DW'(ez));
    chk("busy_ready", DW'(bus.in_ready), 0);
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      chk("hold_valid", DW'(bus.out_valid), 1);
      chk("hold_ready", DW'(bus.in_ready), 0);
      chk("hold_quotient", bus.quotient, eq);
      chk("hold_remainder", DW'(bus.remainder), DW'(er));
    end
    gq = bus.quotient;
    gr = bus.remainder;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_valid", DW'(bus.out_valid), 0);
    chk("release_ready", DW'(bus.in_ready), 1);
    chk("release_dbz", DW'(bus.div_by_zero), 0);
    chk("kept_quotient", bus.quotient, eq);
  endtask
  initial begin
    logic [DW-1:0] gq, a;
    logic [N-2:0] gr;
    logic [N-1:0] x, y;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    #12;
    chk("rst_in_ready", DW'(bus.in_ready), 1);
    chk("rst_out_valid", DW'(bus.out_valid), 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", DW'(bus.remainder), 0);
    chk("rst_dbz", DW'(bus.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(DW'(5), N'(3), 0, gq, gr);
    chk("sq_q", gq, 3);
    chk("sq_r", DW'(gr), 0);
    do_op(DW'(1) << 204, (N'(1) << 102) | N'(1), 0, gq, gr);
    chk("top_q", gq, (DW'(1) << 102) | DW'(1));
    chk("top_r", DW'(gr), 1);
    a = rnd_dw();
    do_op(a, N'(1), 0, gq, gr);
    chk("unit_q", gq, a);
    chk("unit_r", DW'(gr), 0);
    do_op(rnd_dw(), '0, 3, gq, gr);
    chk("zero_q", gq, 0);
    do_op(rnd_dw(), rnd_n() | N'(1), 50, gq, gr);
    for (int k = 0; k < 40; k++) do_op(rnd_dw(), rnd_n() >> $urandom_range(0, N - 1), $urandom_range(0, 3), gq, gr);
    for (int k = 0; k < 120; k++) begin
      x = rnd_n();
      y = rnd_n();
      if (y == '0) y = N'(1);
      do_op(clmul(x, y), y, $urandom_range(0, 2), gq, gr);
      chk("prod_q", gq, DW'(x));
      chk("prod_r", DW'(gr), 0);
    end
    @(negedge clk);
    bus.dividend = rnd_dw();
    bus.divisor = rnd_n() | (N'(1) << 60);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", DW'(bus.out_valid), 0);
    chk("abort_ready", DW'(bus.in_ready), 1);
    chk("abort_quotient", bus.quotient, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("abort_no_pulse", DW'(bus.out_valid), 0);
    x = rnd_n();
    y = rnd_n() | N'(1);
    do_op(clmul(x, y), y, 1, gq, gr);
    chk("after_abort_q", gq, DW'(x));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
